// File: rtl/neighbour_fetch_pkg.sv
// Shared pixel, group and neighbour-vector types for neighbour_fetch.
// Used by the line RAM and the top level.
`timescale 1ns/1ps
package neighbour_fetch_pkg;

  localparam int GROUP_PIX = 8;
  localparam int ROW_W     = 14;

  typedef logic [7:0] pix_t;
  typedef pix_t [1:GROUP_PIX] grp_t;
  typedef pix_t [0:GROUP_PIX] nbr_t;

endpackage

// File: rtl/neighbour_fetch_line_ram.sv
// One-row line buffer holding the previous row of 8-pixel groups.
// Simple dual port; the registered read returns old data on a same-address write.
`timescale 1ns/1ps
module line_ram
  import neighbour_fetch_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output grp_t          rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  grp_t          wr_data_i
);

  grp_t mem_q [0:(1<<AW)-1];
  grp_t rd_q;

  // Write the current group and capture the previous row's group at once.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/neighbour_fetch.sv
// Two-stage neighbour fetch: stage A reads the line RAM, stage B assembles
// Ra/Rc/above vectors. Define UHJLS_ROWCNT_EN to add the o_row row index.
`timescale 1ns/1ps
module neighbour_fetch
  import neighbour_fetch_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          i_sof,
  input  logic [AW-1:0] i_wg,
  input  logic          i_vl,
  input  grp_t          i_x,
  output logic          o_vl,
  output logic          o_sp,
  output nbr_t          o_x,
  output nbr_t          o_b,
  output logic          o_eol
`ifdef UHJLS_ROWCNT_EN
  ,
  output logic [ROW_W-1:0] o_row
`endif
);

  logic          acc;
  logic          sof_acc;
  logic [AW-1:0] gcol_q, gcol_d;
  logic [AW-1:0] wg_q, wg_d;
  logic [AW-1:0] col_c;
  logic          first_q, first_d, first_c;
  logic          sp_c, eol_c;

  logic          a_vl_q, a_sp_q, a_eol_q, a_first_q;
  grp_t          a_x_q;
  grp_t          ram_q;

  grp_t          up_c;
  pix_t          xl_c, bl_c;
  pix_t          rc_q;
  nbr_t          x_d, b_d;

  assign acc     = ena & i_vl;
  assign sof_acc = acc & i_sof;

  // Column/width/first-row view of the group being accepted now.
  always_comb begin
    col_c   = gcol_q;
    wg_d    = wg_q;
    first_c = first_q;
    if (sof_acc) begin
      col_c   = '0;
      first_c = 1'b1;
      wg_d    = (i_wg == '0) ? AW'(1) : i_wg;
    end
    eol_c   = (col_c == wg_d - AW'(1));
    sp_c    = (col_c == '0);
    gcol_d  = eol_c ? '0 : col_c + AW'(1);
    first_d = first_c & ~eol_c;
  end

  // Column counter, latched width and first-row flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcol_q  <= '0;
      wg_q    <= AW'(1);
      first_q <= 1'b1;
    end else if (acc) begin
      gcol_q  <= gcol_d;
      wg_q    <= wg_d;
      first_q <= first_d;
    end
  end

  line_ram #(.AW(AW)) u_ram (
    .clk       (clk),
    .rd_en_i   (acc),
    .rd_addr_i (col_c),
    .rd_data_o (ram_q),
    .wr_en_i   (acc),
    .wr_addr_i (col_c),
    .wr_data_i (i_x)
  );

  // Stage A: register the group and its row-position flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vl_q    <= 1'b0;
      a_sp_q    <= 1'b0;
      a_eol_q   <= 1'b0;
      a_first_q <= 1'b1;
      a_x_q     <= '0;
    end else if (ena) begin
      a_vl_q <= i_vl;
      if (i_vl) begin
        a_sp_q    <= sp_c;
        a_eol_q   <= eol_c;
        a_first_q <= first_c;
        a_x_q     <= i_x;
      end
    end
  end

  // Stage B: mask the first row and pick left/upper-left neighbours.
  always_comb begin
    up_c = a_first_q ? '0 : ram_q;
    if (a_sp_q) begin
      xl_c = up_c[1];
      bl_c = a_first_q ? '0 : rc_q;
    end else begin
      xl_c = o_x[GROUP_PIX];
      bl_c = o_b[GROUP_PIX];
    end
    x_d = {xl_c, a_x_q};
    b_d = {bl_c, up_c};
  end

  // Output registers; Rc holds the left edge emitted at the last row start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vl  <= 1'b0;
      o_sp  <= 1'b0;
      o_eol <= 1'b0;
      o_x   <= '0;
      o_b   <= '0;
      rc_q  <= '0;
    end else if (ena) begin
      o_vl <= a_vl_q;
      if (a_vl_q) begin
        o_sp  <= a_sp_q;
        o_eol <= a_eol_q;
        o_x   <= x_d;
        o_b   <= b_d;
        if (a_sp_q) rc_q <= xl_c;
      end
    end
  end

`ifdef UHJLS_ROWCNT_EN
  logic [ROW_W-1:0] row_q, row_d, row_c, a_row_q;

  // Row index of the accepted group and of the next one.
  always_comb begin
    row_c = sof_acc ? '0 : row_q;
    row_d = eol_c ? row_c + ROW_W'(1) : row_c;
  end

  // Row counter carried alongside the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      a_row_q <= '0;
      o_row   <= '0;
    end else if (ena) begin
      if (i_vl) begin
        row_q   <= row_d;
        a_row_q <= row_c;
      end
      if (a_vl_q) o_row <= a_row_q;
    end
  end
`endif

endmodule

// File: tb/tb_neighbour_fetch.sv
// Randomised scoreboard bench for neighbour_fetch.
// A frame-level reference model predicts every output group.
`timescale 1ns/1ps
module tb_neighbour_fetch;
  import neighbour_fetch_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, ena, i_sof, i_vl;
  logic [AW-1:0] i_wg;
  grp_t          i_x;
  logic          o_vl, o_sp, o_eol;
  nbr_t          o_x, o_b;
`ifdef UHJLS_ROWCNT_EN
  logic [13:0]   o_row;
`endif

  always #5 clk = ~clk;

  neighbour_fetch #(.AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .i_sof (i_sof),
    .i_wg  (i_wg),
    .i_vl  (i_vl),
    .i_x   (i_x),
    .o_vl  (o_vl),
    .o_sp  (o_sp),
    .o_x   (o_x),
    .o_b   (o_b),
    .o_eol (o_eol)
`ifdef UHJLS_ROWCNT_EN
    ,
    .o_row (o_row)
`endif
  );

  typedef struct {
    logic sp;
    logic eol;
    nbr_t x;
    nbr_t b;
    int   row;
    int   tag;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   have_last = 0;
  bit   en_s = 0;
  int   ecyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Reference model: previous row kept as an array of groups.
  int   m_col, m_wg, m_row;
  bit   m_first;
  grp_t m_above [0:(1<<AW)-1];
  pix_t m_px8, m_pb8, m_rc;

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_col = 0; m_wg = 1; m_row = 0; m_first = 1;
    m_rc = 0; m_px8 = 0; m_pb8 = 0;
  endtask

  task automatic mdl_accept();
    exp_t e;
    grp_t up;
    if (i_sof) begin
      m_col = 0; m_first = 1; m_row = 0;
      m_wg = (i_wg == 0) ? 1 : int'(i_wg);
    end
    e.sp  = (m_col == 0);
    e.eol = (m_col == m_wg - 1);
    up = m_first ? '0 : m_above[m_col];
    m_above[m_col] = i_x;
    e.x = {(e.sp ? up[1] : m_px8), i_x};
    e.b = {(e.sp ? (m_first ? 8'd0 : m_rc) : m_pb8), up};
    if (e.sp) m_rc = e.x[0];
    m_px8 = i_x[8];
    m_pb8 = up[8];
    e.row = m_row;
    e.tag = ecyc;
    q.push_back(e);
    if (e.eol) begin
      m_col = 0; m_first = 0; m_row = (m_row + 1) % 16384;
    end else begin
      m_col++;
    end
  endtask

  // Capture accepted groups into the model at the edge that takes them.
  always @(posedge clk) begin
    en_s = ena;
    if (ena && !rst) begin
      ecyc++;
      if (i_vl) mdl_accept();
    end
  end

  // Monitor: pop and compare each new output; check hold during stalls.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (en_s) begin
        if (o_vl) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 72'(o_vl), 72'(0));
          end else begin
            e = q.pop_front();
            chk("o_sp", 72'(o_sp), 72'(e.sp));
            chk("o_eol", 72'(o_eol), 72'(e.eol));
            chk("o_x", o_x, e.x);
            chk("o_b", o_b, e.b);
            chk("latency", 72'(ecyc - e.tag + 1), 72'(2));
`ifdef UHJLS_ROWCNT_EN
            chk("o_row", 72'(o_row), 72'(e.row));
`endif
            last = e;
            have_last = 1;
          end
        end
      end else if (o_vl && have_last) begin
        chk("hold_x", o_x, last.x);
        chk("hold_b", o_b, last.b);
      end
    end
  end

  function automatic grp_t mk(int base);
    grp_t g;
    for (int k = 1; k <= 8; k++) g[k] = pix_t'(base + k - 1);
    return g;
  endfunction

  function automatic grp_t rnd();
    grp_t g;
    for (int k = 1; k <= 8; k++) g[k] = pix_t'($urandom_range(0, 255));
    return g;
  endfunction

  task automatic drive(bit vl, bit sof, int wg, grp_t x);
    i_vl = vl; i_sof = sof; i_wg = AW'(wg); i_x = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; ena = 0; i_vl = 0; i_sof = 0; i_wg = '0; i_x = '0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_vl", 72'(o_vl), 72'(0));
    chk("reset_o_sp", 72'(o_sp), 72'(0));
    chk("reset_o_eol", 72'(o_eol), 72'(0));
    chk("reset_o_x", o_x, 72'(0));
    chk("reset_o_b", o_b, 72'(0));
    rst = 0; ena = 1;

    // Rows 0..2, two groups per row.
    for (int r = 0; r < 3; r++)
      for (int g = 0; g < 2; g++)
        drive(1, (r == 0 && g == 0), 2, mk(r * 100 + 1 + 8 * g));

    // Row 3: restart the frame on column 1.
    drive(1, 0, 2, mk(31));
    drive(1, 1, 2, mk(41));
    drive(1, 0, 2, mk(51));

    // Valid gap.
    drive(1, 0, 2, mk(61));
    drive(0, 0, 2, mk(0));
    drive(1, 0, 2, mk(71));

    // Three-cycle stall.
    drive(1, 0, 2, mk(81));
    ena = 0;
    for (int i = 0; i < 3; i++) drive(1, 0, 2, mk(91));
    ena = 1;
    drive(1, 0, 2, mk(91));

    // Random traffic with gaps, stalls and frame restarts.
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 7) != 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            $urandom_range(0, 5), rnd());
    end

    // Asynchronous reset pulse in the middle of a row.
    ena = 1;
    drive(1, 1, 3, rnd());
    drive(1, 0, 3, rnd());
    #3;
    rst = 1;
    q.delete();
    mdl_reset();
    have_last = 0;
    #1;
    chk("async_rst_o_vl", 72'(o_vl), 72'(0));
    chk("async_rst_o_sp", 72'(o_sp), 72'(0));
    #1;
    rst = 0;

    // Width 1 from reset, then i_wg=0 restart.
    for (int i = 0; i < 3; i++) drive(1, 0, 5, rnd());
    for (int i = 0; i < 4; i++) drive(1, (i == 0), 0, rnd());
    for (int i = 0; i < 20; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 2) != 0), 0, 7, rnd());
    end

    ena = 1;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, '0);
    chk("drain_empty", 72'(q.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neighbour_fetch.md
NEIGHBOUR_FETCH -- requirements
Module: neighbour_fetch

Interface
REQ-001 The module SHALL have parameter AW, default 10, meaning the log2 of the maximum number of 8-pixel groups per row; the line RAM SHALL hold 2^AW groups.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port ena, input, 1 bit: global pipeline enable; when it is low, all state SHALL hold.
REQ-005 Port i_sof, input, 1 bit: start of frame; it SHALL be qualified by i_vl.
REQ-006 Port i_wg, input, AW bits: row width in groups; it SHALL be sampled on a valid i_sof.
REQ-007 Port i_vl, input, 1 bit: input group valid.
REQ-008 Port i_x[1:8], input, 8 bits each: current-row pixels, left to right.
REQ-009 Port o_vl, output, 1 bit: output group valid.
REQ-010 Port o_sp, output, 1 bit: the output group is the first group of a row.
REQ-011 Port o_x[0:8], output, 8 bits each: o_x[0] is the left neighbour Ra of pixel 1; o_x[1:8] are the current pixels.
REQ-012 Port o_b[0:8], output, 8 bits each: o_b[0] is the upper-left neighbour Rc of pixel 1; o_b[1:8] are the pixels directly above.
REQ-013 Port o_eol, output, 1 bit: the output group is the last group of a row.

Function
REQ-014 Latency SHALL be exactly 2 enabled cycles from i_vl to o_vl.
- Stage A: registered line-RAM read, plus input registers.
- Stage B: neighbour assembly.
REQ-015 Cycles with ena high and i_vl low SHALL produce bubbles (o_vl=0) and SHALL NOT advance any counter.
REQ-016 A column counter gcol (AW bits) SHALL advance on each accepted group.
- It SHALL wrap to 0 after gcol = wg-1.
- The wrap SHALL advance the row counter and clear the first_row flag.
REQ-017 A valid i_sof SHALL force gcol=0, first_row=1 and latch wg, including mid-frame; that group SHALL be treated as column 0.
REQ-018 i_wg=0 SHALL be treated as 1, so every group has o_sp=o_eol=1.
REQ-019 The line RAM SHALL be read and written at address gcol in the same cycle.
- The read SHALL return the old data (read-before-write).
- The write data SHALL be {i_x[1..8]}.
REQ-020 While first_row=1:
- o_b[1:8] SHALL be 0 regardless of RAM contents.
- o_b[0] SHALL be 0.
- o_x[0] at row start SHALL be 0.
REQ-021 At o_sp=1 (not the first row):
- o_x[0] SHALL equal o_b[1].
- o_b[0] SHALL equal the o_x[0] value emitted at the start of the previous row (JPEG-LS Rc rule).
REQ-022 When o_sp=0:
- o_x[0] SHALL equal pixel 8 of the previous group in the same row.
- o_b[0] SHALL equal above-pixel 8 of the previous group.
REQ-023 o_sp and o_eol SHALL both be 1 when wg=1.

Reset
REQ-024 On rst, the following SHALL clear immediately, independent of clk and ena: o_vl, o_sp, o_eol, all stage-valid flags, gcol, wg (to 1), the Rc holding register and the row counter; first_row SHALL be set to 1.
REQ-025 Line RAM contents SHALL NOT be reset; first_row masking SHALL make their initial values irrelevant.
REQ-026 Reset asserted mid-row SHALL discard in-flight groups; after release, the first valid group SHALL be handled as column 0 of a first row.
REQ-027 o_x and o_b SHALL reset to 0.

Configuration
REQ-028 With macro UHJLS_ROWCNT_EN defined:
- An extra output o_row (14 bits, reset 0) SHALL give the row index of the output group.
- o_row SHALL be cleared by i_sof and SHALL wrap from 16383 to 0.
REQ-029 Without UHJLS_ROWCNT_EN:
- The o_row port SHALL be absent and the row counter SHALL be removed.
- All other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold:
- the pixel typedef (8-bit);
- the group typedef (array [1:8] of pixel);
- the neighbour-vector typedef (array [0:8]);
- constant GROUP_PIX=8.
REQ-031 Sub-module line_ram SHALL be a simple dual-port RAM, 2^AW x 64 bits, with a registered read-before-write output and a read enable tied to ena & i_vl.
REQ-032 Counters, first-row logic and neighbour assembly SHALL reside in neighbour_fetch.

Verification
REQ-033 Scenario "first row": wg=2, row 0 pixels 1..16 → o_b all 0; group 0 o_x[0]=0, o_sp=1; group 1 o_x[0]=8, o_eol=1.
REQ-034 Scenario "second row": row 1 pixels 101..116 → group 0 o_b[1:8]=1..8, o_x[0]=1, o_b[0]=0; group 1 o_b[0]=8, o_x[0]=108.
REQ-035 Scenario "Rc rule": third row (row 2) → at o_sp, o_b[0]=1 (the row-1 start o_x[0]) and o_x[0]=101.
REQ-036 Scenario "bubbles and stall":
- i_vl toggling 1,0,1 → outputs identical to the gapless run, shifted by the gaps.
- ena low for 3 cycles → outputs frozen.
REQ-037 Scenario "mid-frame i_sof": i_sof during column 1 of row 3 → that group gets o_sp=1 and o_b=0; with UHJLS_ROWCNT_EN, o_row=0.
REQ-038 Scenario "async reset and wg=1": rst pulse between clock edges mid-row → o_vl=0 immediately; then wg=1 → every output group has o_sp=o_eol=1, and from row 1 onward o_x[0]=o_b[1].
